// File: rtl/memoria.sv
// MEM stage of the pipelined MIPS core: 256x32 data RAM with sized loads/stores,
// a word-wide debug back door and a sticky dirty flag for pipeline stores.
module memoria #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_CTRL = 6,
  parameter int ADDRWIDTH   = 10
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable_mem,
  input  logic [NB_MEM_CTRL-1:0] i_MEM_control,
  input  logic [ADDRWIDTH-1:0]   i_alu_result,
  input  logic [NB_DATA-1:0]     i_data_write,
  input  logic [ADDRWIDTH-1:0]   i_addr_mem_debug_unit,
  input  logic                   i_ctrl_addr_debug_mem,
  input  logic                   i_ctrl_wr_debug_mem,
  output logic                   o_bit_sucio,
  output logic [NB_DATA-1:0]     o_data_mem_debug_unit,
  output logic [NB_DATA-1:0]     o_mem_data
);

  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_BYTE = 3'b010;

  logic [NB_DATA-1:0] mem [256] = '{default: '0};

  logic       mem_read;
  logic       mem_write;
  logic       is_signed;
  logic [2:0] size;
  logic [7:0] pipe_idx;
  logic [1:0] lane;
  logic [7:0] dbg_idx;

  assign mem_read  = i_MEM_control[5];
  assign mem_write = i_MEM_control[4];
  assign is_signed = i_MEM_control[3];
  assign size      = i_MEM_control[2:0];
  assign pipe_idx  = i_alu_result[9:2];
  assign lane      = i_alu_result[1:0];
  assign dbg_idx   = i_addr_mem_debug_unit[7:0];

  logic pipe_store;
  logic debug_store;

  // Debug ownership blocks the pipeline, so both writes never coincide.
  assign pipe_store  = i_reset && i_enable_mem && mem_write && !i_ctrl_addr_debug_mem;
  assign debug_store = i_reset && i_ctrl_addr_debug_mem && i_ctrl_wr_debug_mem;

  logic [3:0]         byte_en;
  logic [NB_DATA-1:0] store_data;

  always_comb begin
    byte_en    = 4'b1111;
    store_data = i_data_write;
    case (size)
      SIZE_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{i_data_write[15:0]}};
      end
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{i_data_write[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (debug_store) begin
      mem[dbg_idx] <= i_data_write;
    end else if (pipe_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[pipe_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_bit_sucio <= 1'b0;
    end else if (pipe_store) begin
      o_bit_sucio <= 1'b1;
    end
  end

  logic [NB_DATA-1:0] load_word;
  logic [15:0]        load_half;
  logic [7:0]         load_byte;

  assign load_word = mem[pipe_idx];
  assign load_half = lane[1] ? load_word[31:16] : load_word[15:0];
  assign load_byte = load_word[8*lane +: 8];

  always_comb begin
    o_mem_data = '0;
    if (mem_read) begin
      case (size)
        SIZE_HALF: o_mem_data = {{16{is_signed & load_half[15]}}, load_half};
        SIZE_BYTE: o_mem_data = {{24{is_signed & load_byte[7]}}, load_byte};
        default:   o_mem_data = load_word;
      endcase
    end
  end

  assign o_data_mem_debug_unit = mem[dbg_idx];

endmodule

// File: tb/tb_memoria.sv
// Directed bench for memoria: hand-computed expectations checked with immediate assertions.
module tb_memoria;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [5:0]  ctrl;
  logic [9:0]  alu_addr;
  logic [31:0] wdata;
  logic [9:0]  dbg_addr;
  logic        dbg_own;
  logic        dbg_wr;
  logic        dirty;
  logic [31:0] dbg_data;
  logic [31:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;

  memoria dut (
    .i_clock               (clk),
    .i_reset               (rst_n),
    .i_enable_mem          (enable),
    .i_MEM_control         (ctrl),
    .i_alu_result          (alu_addr),
    .i_data_write          (wdata),
    .i_addr_mem_debug_unit (dbg_addr),
    .i_ctrl_addr_debug_mem (dbg_own),
    .i_ctrl_wr_debug_mem   (dbg_wr),
    .o_bit_sucio           (dirty),
    .o_data_mem_debug_unit (dbg_data),
    .o_mem_data            (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    ctrl     = 6'b010000;
    alu_addr = 10'd0;
    wdata    = 32'h12345678;
    dbg_addr = 10'd0;
    dbg_own  = 1'b0;
    dbg_wr   = 1'b0;

    // Reset for two cycles with a store presented: store must be cancelled.
    step();
    step();
    chk("reset_dirty", {31'b0, dirty}, 32'h0);
    chk("reset_word0", dbg_data, 32'h0);

    // Word store then load.
    rst_n = 1'b1;
    ctrl  = 6'b011000;
    #1;
    chk("dirty_before_store", {31'b0, dirty}, 32'h0);
    step();
    chk("word_store_dirty", {31'b0, dirty}, 32'h1);
    ctrl = 6'b101000;
    #1;
    chk("word_load", mem_data, 32'h12345678);
    chk("word_dbg_read", dbg_data, 32'h12345678);

    // Byte store at address 5; upper data bits must not leak.
    ctrl     = 6'b010010;
    alu_addr = 10'd5;
    wdata    = 32'hAABBCCF0;
    step();
    ctrl = 6'b101010;
    #1;
    chk("lb_signed", mem_data, 32'hFFFFFFF0);
    ctrl = 6'b100010;
    #1;
    chk("lbu", mem_data, 32'h000000F0);
    ctrl     = 6'b101001;
    alu_addr = 10'd4;
    #1;
    chk("lh_signed", mem_data, 32'hFFFFF000);
    ctrl     = 6'b100001;
    alu_addr = 10'd6;
    #1;
    chk("lhu_upper", mem_data, 32'h00000000);
    ctrl     = 6'b101000;
    alu_addr = 10'd4;
    #1;
    chk("word1_after_byte", mem_data, 32'h0000F000);

    // Read and write the same word: old data visible until the edge.
    ctrl     = 6'b111000;
    alu_addr = 10'd0;
    wdata    = 32'h00000055;
    #1;
    chk("rw_before_edge", mem_data, 32'h12345678);
    step();
    chk("rw_after_edge", mem_data, 32'h00000055);

    // Halfword store into upper half of word 0 (address bit 0 ignored).
    ctrl     = 6'b010001;
    alu_addr = 10'd3;
    wdata    = 32'h1234BEEF;
    step();
    chk("sh_upper", dbg_data, 32'hBEEF0055);

    // Clear dirty with a one-cycle reset.
    rst_n = 1'b0;
    ctrl  = 6'b000000;
    step();
    rst_n = 1'b1;
    chk("reset_clears_dirty", {31'b0, dirty}, 32'h0);
    chk("reset_keeps_ram", dbg_data, 32'hBEEF0055);

    // Debug ownership blocks pipeline store.
    dbg_own  = 1'b1;
    dbg_addr = 10'd2;
    ctrl     = 6'b010000;
    alu_addr = 10'd8;
    wdata    = 32'hDEADBEEF;
    step();
    chk("own_block_word2", dbg_data, 32'h0);
    chk("own_block_dirty", {31'b0, dirty}, 32'h0);

    // Debug write, upper index bits ignored, independent of enable.
    enable   = 1'b0;
    dbg_wr   = 1'b1;
    dbg_addr = 10'h302;
    ctrl     = 6'b100000;
    wdata    = 32'hCAFEF00D;
    step();
    chk("dbg_write", dbg_data, 32'hCAFEF00D);
    chk("dbg_write_no_dirty", {31'b0, dirty}, 32'h0);
    chk("load_while_owned", mem_data, 32'hCAFEF00D);

    // Debug write suppressed under reset.
    rst_n    = 1'b0;
    dbg_addr = 10'd3;
    wdata    = 32'h11111111;
    step();
    rst_n  = 1'b1;
    dbg_wr = 1'b0;
    chk("dbg_write_reset", dbg_data, 32'h0);

    // Stall: store to addr 12 with enable low.
    dbg_own  = 1'b0;
    enable   = 1'b0;
    ctrl     = 6'b010000;
    alu_addr = 10'd12;
    wdata    = 32'h00000077;
    step();
    chk("stall_word3", dbg_data, 32'h0);
    chk("stall_dirty", {31'b0, dirty}, 32'h0);
    enable = 1'b1;
    step();
    chk("unstall_word3", dbg_data, 32'h00000077);
    chk("unstall_dirty", {31'b0, dirty}, 32'h1);

    // Byte lane 3 store and loads.
    ctrl     = 6'b010010;
    alu_addr = 10'd15;
    wdata    = 32'h00000080;
    step();
    chk("sb_lane3", dbg_data, 32'h80000077);
    ctrl = 6'b101010;
    #1;
    chk("lb_lane3", mem_data, 32'hFFFFFF80);
    ctrl     = 6'b100001;
    alu_addr = 10'd14;
    #1;
    chk("lhu_upper_w3", mem_data, 32'h00008000);
    ctrl     = 6'b101011;
    alu_addr = 10'd13;
    #1;
    chk("size011_word", mem_data, 32'h80000077);

    // Read disabled.
    ctrl     = 6'b001010;
    alu_addr = 10'd12;
    #1;
    chk("read_off_a12", mem_data, 32'h0);
    alu_addr = 10'd0;
    #1;
    chk("read_off_a0", mem_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memoria.md
# memoria

Data-memory (MEM) stage of the pipelined MIPS core. It holds a 256 × 32 data RAM and performs pipeline loads and stores: byte, halfword and word, with sign or zero extension on loads. It also gives the debug unit a word-wide back door for reading and writing memory. A sticky dirty bit tells the debug unit that the program has written to memory since reset.

## Interface
- NB_DATA, 32, data word width
- NB_MEM_CTRL, 6, width of the MEM control bundle
- ADDRWIDTH, 10, address width of i_alu_result and i_addr_mem_debug_unit

Ports:
- i_clock  in  1  single clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-low reset
- i_enable_mem  in  1  stage enable; low = stall, no pipeline write, dirty bit held
- i_MEM_control  in  NB_MEM_CTRL  control bundle:
  - [5] MemRead
  - [4] MemWrite
  - [3] Signed (1 = sign-extend loads)
  - [2:0] Size: 000 word, 001 halfword, 010 byte; other codes act as word
- i_alu_result  in  ADDRWIDTH  pipeline byte address
- i_data_write  in  NB_DATA  store data; also the debug write data
- i_addr_mem_debug_unit  in  ADDRWIDTH  debug word index; bits [7:0] used, upper bits ignored
- i_ctrl_addr_debug_mem  in  1  1 = debug unit owns the memory; pipeline stores blocked
- i_ctrl_wr_debug_mem  in  1  debug full-word write strobe; effective only when i_ctrl_addr_debug_mem=1
- o_bit_sucio  out  1  dirty bit, sticky
- o_data_mem_debug_unit  out  NB_DATA  word at the debug index
- o_mem_data  out  NB_DATA  sized and extended load result

## Operation
- Storage is 256 words × 32 bits.
  - Pipeline word index = i_alu_result[9:2].
  - Byte lane = i_alu_result[1:0]; lane 0 = bits [7:0] (little-endian).
- RAM initialises to all zeros at configuration. Reset does not clear RAM contents.
- Pipeline store condition: i_enable_mem=1, MemWrite=1 and i_ctrl_addr_debug_mem=0. When it holds:
  - Word: write i_data_write to the whole word; offset bits ignored.
  - Halfword: write i_data_write[15:0] to half i_alu_result[1]; bit 0 ignored.
  - Byte: write i_data_write[7:0] to lane i_alu_result[1:0].
  - Other bytes of the word are unchanged.
- Debug write condition: i_ctrl_addr_debug_mem=1 and i_ctrl_wr_debug_mem=1. The full i_data_write word goes to index i_addr_mem_debug_unit[7:0]. It is independent of i_enable_mem and of MemWrite.
- Load (combinational). When MemRead=1, o_mem_data returns the addressed word:
  - Word: returned unchanged.
  - Halfword: the selected half, sign-extended from bit 15 if Signed=1, else zero-extended.
  - Byte: the selected lane, sign-extended from bit 7 if Signed=1, else zero-extended.
- When MemRead=0, o_mem_data = 0.
- Loads always use i_alu_result, including while the debug unit owns the memory.
- o_data_mem_debug_unit always shows the full word at i_addr_mem_debug_unit[7:0], combinationally.
- Dirty bit:
  - o_bit_sucio is set on the clock edge of any committed pipeline store.
  - Debug writes do not set it.
  - Only reset clears it.

## Timing
- Writes commit on the rising edge. Reads are asynchronous, so both read outputs reflect a write from the cycle after the edge.
- With MemRead and MemWrite both 1 at the same address, o_mem_data shows the pre-write contents until the edge.
- Pipeline store and debug write in the same cycle cannot happen: debug ownership blocks the pipeline store.
- Reset (i_reset=0 at an edge):
  - o_bit_sucio ← 0.
  - Pipeline stores and debug writes are suppressed that cycle.
  - Read outputs keep working and reflect RAM contents.
- Reset mid-operation cancels any store presented in the same cycle.
- i_enable_mem=0 freezes all pipeline-side state; debug access continues.

## Test plan
- Reset: hold i_reset=0 for 2 cycles with MemWrite=1, address 0, data 32'h12345678, enable=1 → o_bit_sucio=0; word 0 stays 0 as read on o_data_mem_debug_unit.
- Word store/load:
  - Release reset, enable=1, ctrl=6'b011000, addr 0, data 32'h12345678, debug ctrl 0; clock → o_bit_sucio=1.
  - Then ctrl=6'b101000, addr 0 → o_mem_data=32'h12345678.
  - o_data_mem_debug_unit at index 0 = 32'h12345678.
- Sub-word:
  - Store byte 8'hF0 at byte address 5 (ctrl 6'b010010).
  - Load signed byte (6'b101010) → 32'hFFFFFFF0; unsigned byte (6'b100010) → 32'h000000F0.
  - Signed halfword from address 4 → 32'hFFFFF000 (word 1 was 0 before the byte store).
- Debug ownership:
  - i_ctrl_addr_debug_mem=1 with pipeline store 32'hDEADBEEF to addr 8 → word 2 unchanged and dirty bit not set by it.
  - Debug write (i_ctrl_wr_debug_mem=1, index 2, data 32'hCAFEF00D) → o_data_mem_debug_unit=32'hCAFEF00D.
- Stall: enable=0 with a store to addr 12 → word 3 unchanged and o_bit_sucio unchanged.
- Read disabled: MemRead=0 → o_mem_data=0 regardless of address.
